dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
//  Memory-stage data-memory bridge for the 5-stage pipelined MIPS core.
//  Consumes the M-stage address/store-data/control and returns load data for the M->W register.
//  Talks to a slow data memory over a req/gnt/rvalid bus. Stores retire into a posted write buffer.
//  Raises stall_m_o to the hazard unit while a load or a full-buffer store is outstanding.
// PARAMETERS
//  WBUF_DEPTH  4   write-buffer entries; power of 2, >=2
//  ADDR_W      32  byte-address width
//  DATA_W      32  data word width
// PORTS
//  clk_i          in   1       clock, all state on rising edge
//  reset_i        in   1       asynchronous, active-high reset
//  memread_m_i    in   1       M-stage load (memtorf_m)
//  memwrite_m_i   in   1       M-stage store
//  addr_m_i       in   ADDR_W  M-stage ALU result (byte address)
//  wdata_m_i      in   DATA_W  M-stage store data
//  rdata_m_o      out  DATA_W  load data to M->W register
//  stall_m_o      out  1       freeze whole pipeline this cycle (comb)
//  err_misalign_o out  1       sticky: access with addr[1:0]!=0 seen
//  bus_req_o      out  1       bus request; held with addr/we/wdata stable until gnt
//  bus_we_o       out  1       1=write, 0=read
//  bus_addr_o     out  ADDR_W  word-aligned address ([1:0]=00)
//  bus_wdata_o    out  DATA_W  write data
//  bus_gnt_i      in   1       request accepted this cycle
//  bus_rvalid_i   in   1       read data valid; >=1 cycle after gnt
//  bus_rdata_i    in   DATA_W  read data
// BEHAVIOUR
//  Reset: FSM=IDLE, wbuf empty, rdata_m_o=0, bus_req_o=0, bus_we_o=0, bus_addr_o=0,
//   bus_wdata_o=0, err_misalign_o=0. stall_m_o=0 with no request present.
//   A reset mid-transaction abandons it; late rvalid is ignored in IDLE.
//  memread_m_i and memwrite_m_i are never both 1; inputs hold stable while stall_m_o=1.
//  Bus: single outstanding transaction. Writes complete on gnt; reads complete on rvalid.
//  Read FSM:
//   IDLE    -> RD_REQ  when memread & wbuf empty; stall=1
//           (memread & wbuf non-empty: stay IDLE, stall=1, buffer drains first)
//   RD_REQ  -> RD_WAIT on gnt; req=1, we=0; stall=1
//   RD_WAIT -> RD_DONE on rvalid, capture rdata_i into rdata_q; stall=1
//   RD_DONE -> IDLE unconditionally; stall=0, rdata_m_o=rdata_q
//  Minimum load stall: 3 cycles with gnt in the same cycle as req and rvalid 1 cycle later.
//   The load advances at the edge that ends RD_DONE.
//  Stores: memwrite & !full -> push {addr,wdata} at the edge, stall=0 (zero-stall retire).
//   memwrite & full -> stall=1 until an entry pops. The push happens in the cycle after the pop (no same-cycle bypass).
//  Drain: when FSM in IDLE and wbuf non-empty, drive head onto bus (req=1, we=1). Pop on gnt.
//   Drain order is FIFO.
//  Simultaneous push and pop: count unchanged; head and tail pointers both advance.
//  Pointers: log2(WBUF_DEPTH)+1 bits; wrap naturally. full = MSBs differ & rest equal.
//  Misaligned: addr[1:0]!=0 on a load or store sets err_misalign_o.
//   The access still proceeds with [1:0] forced to 00.
//  rdata_m_o holds its last load value outside RD_DONE.
// STRUCTURE
//  mips_pkg: typedef enum dmem_state_t {IDLE,RD_REQ,RD_WAIT,RD_DONE};
//   typedef struct wbuf_entry_t {addr,data}.
//  Sub-module wbuf_fifo (WBUF_DEPTH, entry type): push/pop/full/empty/head, async reset.
//  Bus mux, FSM and stall logic stay in dmem_bridge.
// TESTING
//  1 Load, wbuf empty, gnt same cycle as req, rvalid next cycle with 0xDEADBEEF at 0x100
//    -> stall_m_o 1 for 3 cycles, then 0 for 1 cycle with rdata_m_o=0xDEADBEEF.
//  2 Four back-to-back stores, gnt held low
//    -> stall=0 for all four. Fifth store -> stall=1. Raise gnt -> first pop.
//    -> Fifth store pushed the cycle after the pop, then stall=0.
//  3 Store 0x11 to 0x40, then load 0x40 next cycle
//    -> load stalls until the write gets gnt, then issues read.
//    -> Bus order is write then read.
//  4 Store pushed while head pops on the same edge -> count unchanged.
//    -> Over 8 stores with WBUF_DEPTH=4, data drains in order.
//  5 Load to 0x103 -> err_misalign_o=1 (sticky), bus_addr_o=0x100.
//  6 Assert reset_i in RD_WAIT, then rvalid arrives after release
//    -> outputs at reset values, FSM IDLE, rvalid ignored, no stall.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and helpers for the data-memory bridge and its write buffer.
package dmem_bridge_pkg;

  localparam int ADDR_W_C = 32;
  localparam int DATA_W_C = 32;

  // Load-side bus sequencer states; stores never leave IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_REQ  = 2'b01,
    RD_WAIT = 2'b10,
    RD_DONE = 2'b11
  } dmem_state_t;

  // One posted store: word-aligned address plus data.
  typedef struct packed {
    logic [ADDR_W_C-1:0] addr;
    logic [DATA_W_C-1:0] data;
  } wbuf_entry_t;

  // The bus is word-only, so byte offsets are dropped.
  function automatic logic [ADDR_W_C-1:0] word_align(input logic [ADDR_W_C-1:0] a);
    return {a[ADDR_W_C-1:2], 2'b00};
  endfunction

  // Any nonzero byte offset marks a misaligned word access.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_bridge_wbuf_fifo.sv
// Posted-store FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate counter.
module dmem_bridge_wbuf_fifo
  import dmem_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        push_i,
  input  wbuf_entry_t push_data_i,
  input  logic        pop_i,
  output wbuf_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_r;
  logic [PTR_W:0] rd_ptr_r;
  wbuf_entry_t    mem_r [DEPTH];
  logic           push_ok_s;
  logic           pop_ok_s;

  assign empty_o   = (wr_ptr_r == rd_ptr_r);
  assign full_o    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign head_o    = mem_r[rd_ptr_r[PTR_W-1:0]];

  // Advance pointers; a simultaneous push and pop moves both and keeps the count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage, cleared on reset so the head never shows stale data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage data-memory bridge: posts stores into a write buffer, runs loads
// over a single-outstanding req/gnt/rvalid bus after the buffer drains, and
// freezes the pipeline while a load or a store to a full buffer is pending.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  parameter int ADDR_W     = ADDR_W_C,
  parameter int DATA_W     = DATA_W_C
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              memread_m_i,
  input  logic              memwrite_m_i,
  input  logic [ADDR_W-1:0] addr_m_i,
  input  logic [DATA_W-1:0] wdata_m_i,
  output logic [DATA_W-1:0] rdata_m_o,
  output logic              stall_m_o,
  output logic              err_misalign_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  dmem_state_t       state_r;
  logic [DATA_W-1:0] rdata_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              misalign_r;

  logic              push_s;
  logic              pop_s;
  logic              stall_s;
  logic              wbuf_full_s;
  logic              wbuf_empty_s;
  wbuf_entry_t       wbuf_head_s;
  wbuf_entry_t       push_entry_s;
  logic              bus_req_s;
  logic              bus_we_s;
  logic [ADDR_W-1:0] bus_addr_s;
  logic [DATA_W-1:0] bus_wdata_s;

  assign push_entry_s.addr = word_align(addr_m_i);
  assign push_entry_s.data = wdata_m_i;

  dmem_bridge_wbuf_fifo #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .head_o      (wbuf_head_s),
    .full_o      (wbuf_full_s),
    .empty_o     (wbuf_empty_s)
  );

  // Bus mux, buffer push/pop and pipeline stall, decoded from the current state.
  always_comb begin
    stall_s     = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    bus_req_s   = 1'b0;
    bus_we_s    = 1'b0;
    bus_addr_s  = '0;
    bus_wdata_s = '0;
    case (state_r)
      IDLE: begin
        // The buffer drains whenever no load owns the bus.
        if (!wbuf_empty_s) begin
          bus_req_s   = 1'b1;
          bus_we_s    = 1'b1;
          bus_addr_s  = wbuf_head_s.addr;
          bus_wdata_s = wbuf_head_s.data;
          pop_s       = bus_gnt_i;
        end else begin
          pop_s = 1'b0;
        end
        // Loads always wait; stores only when the buffer has no room.
        // A slot freed by a pop this cycle is only usable next cycle.
        if (memread_m_i) begin
          stall_s = 1'b1;
        end else if (memwrite_m_i) begin
          stall_s = wbuf_full_s;
          push_s  = !wbuf_full_s;
        end else begin
          stall_s = 1'b0;
        end
      end
      RD_REQ: begin
        bus_req_s  = 1'b1;
        bus_we_s   = 1'b0;
        bus_addr_s = rd_addr_r;
        stall_s    = 1'b1;
      end
      RD_WAIT: begin
        stall_s = 1'b1;
      end
      RD_DONE: begin
        stall_s = 1'b0;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // Load sequencer: waits for an empty buffer, then request, data, hand-off.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      rdata_r   <= '0;
      rd_addr_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (memread_m_i && wbuf_empty_s) begin
            state_r   <= RD_REQ;
            rd_addr_r <= word_align(addr_m_i);
          end else begin
            state_r <= IDLE;
          end
        end
        RD_REQ: begin
          if (bus_gnt_i) begin
            state_r <= RD_WAIT;
          end else begin
            state_r <= RD_REQ;
          end
        end
        RD_WAIT: begin
          if (bus_rvalid_i) begin
            state_r <= RD_DONE;
            rdata_r <= bus_rdata_i;
          end else begin
            state_r <= RD_WAIT;
          end
        end
        RD_DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Sticky misalignment flag; the access itself still goes out word-aligned.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      misalign_r <= 1'b0;
    end else if ((memread_m_i || memwrite_m_i) && is_misaligned(addr_m_i[1:0])) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign rdata_m_o      = rdata_r;
  assign stall_m_o      = stall_s;
  assign err_misalign_o = misalign_r;
  assign bus_req_o      = bus_req_s;
  assign bus_we_o       = bus_we_s;
  assign bus_addr_o     = bus_addr_s;
  assign bus_wdata_o    = bus_wdata_s;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed scenarios followed by random load/store
// traffic against a program-order memory model and a random-latency slave.
module tb_dmem_bridge;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        memread_m_i;
  logic        memwrite_m_i;
  logic [31:0] addr_m_i;
  logic [31:0] wdata_m_i;
  logic [31:0] rdata_m_o;
  logic        stall_m_o;
  logic        err_misalign_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  dmem_bridge #(.WBUF_DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .memread_m_i    (memread_m_i),
    .memwrite_m_i   (memwrite_m_i),
    .addr_m_i       (addr_m_i),
    .wdata_m_i      (wdata_m_i),
    .rdata_m_o      (rdata_m_o),
    .stall_m_o      (stall_m_o),
    .err_misalign_o (err_misalign_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_gnt_i      (bus_gnt_i),
    .bus_rvalid_i   (bus_rvalid_i),
    .bus_rdata_i    (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  bit          mis_model;
  bit          rd_pending;
  int          rd_delay;
  logic [31:0] rd_addr;
  logic [31:0] cur_al;
  int          gnt_pct;

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return mem_default(a);
  endfunction

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    if (slv_mem.exists(a)) return slv_mem[a];
    return mem_default(a);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    memread_m_i  = 1'b0;
    memwrite_m_i = 1'b0;
    addr_m_i     = 32'h0;
    wdata_m_i    = 32'h0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;
  endtask

  // Random slave: drive rvalid/gnt at the start of a cycle.
  task automatic slave_begin();
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;
    if (rd_pending) begin
      if (rd_delay == 0) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = slv_read(rd_addr);
      end else begin
        rd_delay--;
      end
    end
    bus_gnt_i = ($urandom_range(0, 99) < gnt_pct);
  endtask

  // Random slave: observe handshakes mid-cycle and check bus ordering.
  task automatic slave_sample();
    wr_t e;
    if (bus_rvalid_i) rd_pending = 1'b0;
    if (bus_req_o && bus_gnt_i) begin
      if (bus_we_o) begin
        check_val("wr_has_pending_store", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          check_val("wr_addr_order", bus_addr_o, e.a);
          check_val("wr_data_order", bus_wdata_o, e.d);
        end
        slv_mem[bus_addr_o] = bus_wdata_o;
      end else begin
        check_val("rd_after_drain", 32'(wq.size()), 32'd0);
        check_val("rd_addr", bus_addr_o, cur_al);
        rd_pending = 1'b1;
        rd_addr    = bus_addr_o;
        rd_delay   = $urandom_range(0, 2);
      end
    end
  endtask

  task automatic run_random(input int n_ops);
    int          kind;
    int          cyc;
    bit          done;
    bit          is_ld;
    bit          is_st;
    logic [31:0] a;
    for (int k = 0; k < n_ops; k++) begin
      gnt_pct = (k < n_ops / 2) ? 30 : 85;
      kind  = $urandom_range(0, 9);
      is_ld = (kind >= 2) && (kind < 6);
      is_st = (kind >= 6);
      a     = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
      memread_m_i  = is_ld;
      memwrite_m_i = is_st;
      addr_m_i     = a;
      wdata_m_i    = $urandom();
      cur_al       = {a[31:2], 2'b00};
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 200) begin
        slave_begin();
        @(negedge clk_i);
        check_val("err_sticky", 32'(err_misalign_o), 32'(mis_model));
        if (is_st) begin
          check_val("st_stall", 32'(stall_m_o), 32'(wq.size() == DEPTH));
        end else if (is_ld) begin
          if (cyc < 3 || wq.size() != 0) check_val("ld_stall", 32'(stall_m_o), 32'd1);
          if (!stall_m_o) check_val("ld_data", rdata_m_o, ref_read(cur_al));
        end else begin
          check_val("nop_stall", 32'(stall_m_o), 32'd0);
        end
        slave_sample();
        if (!stall_m_o) begin
          done = 1'b1;
          if (is_st) begin
            wq.push_back('{a: cur_al, d: wdata_m_i});
            ref_mem[cur_al] = wdata_m_i;
          end
        end
        if ((is_ld || is_st) && a[1:0] != 2'b00) mis_model = 1'b1;
        tick();
        cyc++;
      end
      check_val("op_done", 32'(done), 32'd1);
    end
    // Let the buffer empty out and check the remaining writes.
    memread_m_i  = 1'b0;
    memwrite_m_i = 1'b0;
    gnt_pct      = 70;
    for (int c = 0; c < 100 && wq.size() != 0; c++) begin
      slave_begin();
      @(negedge clk_i);
      slave_sample();
      tick();
    end
    check_val("drain_empty", 32'(wq.size()), 32'd0);
    bus_gnt_i = 1'b0;
    @(negedge clk_i);
    check_val("drain_no_req", 32'(bus_req_o), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Reset values
    @(negedge clk_i);
    check_val("rst_stall", 32'(stall_m_o), 32'd0);
    check_val("rst_req", 32'(bus_req_o), 32'd0);
    check_val("rst_we", 32'(bus_we_o), 32'd0);
    check_val("rst_addr", bus_addr_o, 32'h0);
    check_val("rst_wdata", bus_wdata_o, 32'h0);
    check_val("rst_rdata", rdata_m_o, 32'h0);
    check_val("rst_err", 32'(err_misalign_o), 32'd0);

    // Minimum-latency load: 3 stall cycles, then data with stall low
    tick();
    memread_m_i = 1'b1;
    addr_m_i    = 32'h100;
    @(negedge clk_i);
    check_val("t1_stall0", 32'(stall_m_o), 32'd1);
    check_val("t1_noreq0", 32'(bus_req_o), 32'd0);
    tick();
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    check_val("t1_stall1", 32'(stall_m_o), 32'd1);
    check_val("t1_req", 32'(bus_req_o), 32'd1);
    check_val("t1_we", 32'(bus_we_o), 32'd0);
    check_val("t1_addr", bus_addr_o, 32'h100);
    tick();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check_val("t1_stall2", 32'(stall_m_o), 32'd1);
    tick();
    bus_rvalid_i = 1'b0;
    @(negedge clk_i);
    check_val("t1_stall3", 32'(stall_m_o), 32'd0);
    check_val("t1_rdata", rdata_m_o, 32'hDEAD_BEEF);
    tick();
    memread_m_i = 1'b0;
    @(negedge clk_i);
    check_val("t1_hold", rdata_m_o, 32'hDEAD_BEEF);

    // Four stores fill the buffer without stalling; the fifth waits for a pop
    for (int i = 0; i < 5; i++) begin
      tick();
      memwrite_m_i = 1'b1;
      addr_m_i     = 32'h200 + 32'(4 * i);
      wdata_m_i    = 32'h1000_0000 + 32'(i);
      @(negedge clk_i);
      check_val("t2_stall", 32'(stall_m_o), (i < 4) ? 32'd0 : 32'd1);
    end
    check_val("t2_head_addr", bus_addr_o, 32'h200);
    check_val("t2_head_we", 32'(bus_we_o), 32'd1);
    tick();
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    check_val("t2_stall_at_pop", 32'(stall_m_o), 32'd1);
    tick();
    bus_gnt_i = 1'b0;
    @(negedge clk_i);
    check_val("t2_stall_after_pop", 32'(stall_m_o), 32'd0);
    check_val("t2_next_head", bus_addr_o, 32'h204);
    tick();
    memwrite_m_i = 1'b0;
    bus_gnt_i    = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk_i);
      check_val("t2_drain_addr", bus_addr_o, 32'h200 + 32'(4 * i));
      check_val("t2_drain_data", bus_wdata_o, 32'h1000_0000 + 32'(i));
      tick();
    end
    bus_gnt_i = 1'b0;
    @(negedge clk_i);
    check_val("t2_empty_req", 32'(bus_req_o), 32'd0);

    // Misaligned load goes out aligned and sets the sticky flag
    tick();
    memread_m_i = 1'b1;
    addr_m_i    = 32'h103;
    @(negedge clk_i);
    check_val("t5_err_before", 32'(err_misalign_o), 32'd0);
    tick();
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    check_val("t5_err", 32'(err_misalign_o), 32'd1);
    check_val("t5_addr", bus_addr_o, 32'h100);
    tick();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h0BAD_F00D;
    tick();
    bus_rvalid_i = 1'b0;
    @(negedge clk_i);
    check_val("t5_rdata", rdata_m_o, 32'h0BAD_F00D);
    tick();
    memread_m_i = 1'b0;
    @(negedge clk_i);
    check_val("t5_err_sticky", 32'(err_misalign_o), 32'd1);

    // Reset while waiting for read data; late rvalid must be ignored
    tick();
    memread_m_i = 1'b1;
    addr_m_i    = 32'h300;
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i   = 1'b0;
    memread_m_i = 1'b0;
    reset_i     = 1'b1;
    @(negedge clk_i);
    check_val("t6_stall", 32'(stall_m_o), 32'd0);
    check_val("t6_req", 32'(bus_req_o), 32'd0);
    check_val("t6_rdata", rdata_m_o, 32'h0);
    check_val("t6_err", 32'(err_misalign_o), 32'd0);
    tick();
    reset_i      = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h5555_5555;
    @(negedge clk_i);
    check_val("t6_late_stall", 32'(stall_m_o), 32'd0);
    check_val("t6_late_req", 32'(bus_req_o), 32'd0);
    tick();
    bus_rvalid_i = 1'b0;
    @(negedge clk_i);
    check_val("t6_rdata_ignored", rdata_m_o, 32'h0);

    // Random traffic against the program-order model
    slv_mem.delete();
    ref_mem.delete();
    wq.delete();
    rd_pending = 1'b0;
    rd_delay   = 0;
    rd_addr    = 32'h0;
    mis_model  = 1'b0;
    tick();
    run_random(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
